// File: rtl/dcnn_dma_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcnn_dma_pkg
// Purpose  : Shared definitions for the DCNN accelerator DMA engines:
//            default geometry, write-back FSM states and DMA RW encoding.
// Revision : 1.0 - initial release
// ============================================================================
package dcnn_dma_pkg;

    // Default geometry: 16-bit addresses, 16-bit fixed-point words, 5x5 tile
    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 16;
    localparam int BLOCK_SIZE = 25;

    // DMA port RW encoding, common to the read and write engines
    localparam logic DMA_READ  = 1'b1;
    localparam logic DMA_WRITE = 1'b0;

    // Write-back engine states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } wb_state_t;

endpackage : dcnn_dma_pkg
`default_nettype wire

// File: rtl/wb_block_buffer.sv
`default_nettype none
// ============================================================================
// Module   : wb_block_buffer
// Purpose  : Holding registers for one result block. Loads the whole packed
//            block in one cycle and returns the word selected by rd_idx_i.
//            Build option DMA_WB_RELU_EN: negative words are replaced by zero
//            as they are loaded.
// Revision : 1.0 - initial release
// ============================================================================
module wb_block_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int BLOCK_SIZE = 25,
    parameter int IDX_W      = 5
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             load_i,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] block_i,
    input  logic [IDX_W-1:0]                 rd_idx_i,
    output logic [DATA_WIDTH-1:0]            load_word0_o,
    output logic [DATA_WIDTH-1:0]            rd_word_o
);

    logic [DATA_WIDTH-1:0] in_words [BLOCK_SIZE];
    logic [DATA_WIDTH-1:0] hold_q   [BLOCK_SIZE];

    // Unpack the incoming block and condition each word for storage
    for (genvar j = 0; j < BLOCK_SIZE; j++) begin : g_unpack
        logic [DATA_WIDTH-1:0] raw;
        assign raw = block_i[j*DATA_WIDTH +: DATA_WIDTH];
`ifdef DMA_WB_RELU_EN
        assign in_words[j] = raw[DATA_WIDTH-1] ? '0 : raw;
`else
        assign in_words[j] = raw;
`endif
    end

    // Word 0 goes out in the same edge that captures the block
    assign load_word0_o = in_words[0];

    // Capture the whole block when the engine accepts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < BLOCK_SIZE; j++) hold_q[j] <= '0;
        end else if (load_i) begin
            for (int j = 0; j < BLOCK_SIZE; j++) hold_q[j] <= in_words[j];
        end
    end

    // Word select; the index one past the last word reads as zero
    always_comb begin
        rd_word_o = '0;
        if ({1'b0, rd_idx_i} < (IDX_W+1)'(BLOCK_SIZE)) rd_word_o = hold_q[rd_idx_i];
    end

endmodule : wb_block_buffer
`default_nettype wire

// File: rtl/dma_writeback.sv
`default_nettype none
// ============================================================================
// Module   : dma_writeback
// Purpose  : Result write-back engine. Accepts one packed block of results
//            in a single handshake and writes it word by word to the DMA
//            port at consecutive addresses from base_addr_i.
//            Build option DMA_WB_RELU_EN (in wb_block_buffer): ReLU at capture.
// Revision : 1.0 - initial release
// ============================================================================
module dma_writeback #(
    parameter int ADDR_WIDTH = dcnn_dma_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = dcnn_dma_pkg::DATA_WIDTH,
    parameter int BLOCK_SIZE = dcnn_dma_pkg::BLOCK_SIZE
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start_i,
    input  logic [ADDR_WIDTH-1:0]            base_addr_i,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] block_in_i,
    output logic                             ready_o,
    output logic                             done_o,
    output logic                             mem_enable_o,
    output logic                             mem_rw_o,
    output logic [ADDR_WIDTH-1:0]            mem_address_o,
    output logic [DATA_WIDTH-1:0]            mem_data_o
);
    import dcnn_dma_pkg::*;

    localparam int              IDX_W    = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SIZE - 1);

    wb_state_t             state_q;
    logic [IDX_W-1:0]      idx_q;
    logic [IDX_W-1:0]      idx_d;
    logic [ADDR_WIDTH-1:0] base_q;
    logic                  ready_q;
    logic                  done_q;
    logic                  enable_q;
    logic [ADDR_WIDTH-1:0] address_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  load;
    logic [DATA_WIDTH-1:0] load_word0;
    logic [DATA_WIDTH-1:0] next_word;

    // Block is captured only on a start seen in IDLE
    assign load  = (state_q == IDLE) && start_i;
    assign idx_d = idx_q + IDX_W'(1);

    wb_block_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .BLOCK_SIZE (BLOCK_SIZE),
        .IDX_W      (IDX_W)
    ) u_buffer (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (load),
        .block_i      (block_in_i),
        .rd_idx_i     (idx_d),
        .load_word0_o (load_word0),
        .rd_word_o    (next_word)
    );

    // Sequencer: every output is a register updated here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            base_q    <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            enable_q  <= 1'b0;
            address_q <= '0;
            data_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        // Word 0 is presented straight from the accepted block
                        state_q   <= WRITE;
                        ready_q   <= 1'b0;
                        enable_q  <= 1'b1;
                        base_q    <= base_addr_i;
                        idx_q     <= '0;
                        address_q <= base_addr_i;
                        data_q    <= load_word0;
                    end
                end
                WRITE: begin
                    if (idx_q == LAST_IDX) begin
                        state_q   <= DONE;
                        enable_q  <= 1'b0;
                        done_q    <= 1'b1;
                        idx_q     <= '0;
                        address_q <= '0;
                        data_q    <= '0;
                    end else begin
                        // Address wraps modulo 2^ADDR_WIDTH by truncation
                        idx_q     <= idx_d;
                        address_q <= base_q + ADDR_WIDTH'(idx_d);
                        data_q    <= next_word;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q  <= IDLE;
                    ready_q  <= 1'b1;
                    done_q   <= 1'b0;
                    enable_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o       = ready_q;
    assign done_o        = done_q;
    assign mem_enable_o  = enable_q;
    assign mem_rw_o      = DMA_WRITE;
    assign mem_address_o = address_q;
    assign mem_data_o    = data_q;

endmodule : dma_writeback
`default_nettype wire

// File: tb/tb_dma_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_writeback
// Purpose  : Self-checking bench for dma_writeback (table vectors, directed
//            corner sequences and randomized blocks against a word-list model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_writeback;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int BS = 25;

    logic           clk       = 1'b0;
    logic           rst_n     = 1'b0;
    logic           start     = 1'b0;
    logic [AW-1:0]  base_addr = '0;
    logic [BS*DW-1:0] block_in = '0;
    logic           ready;
    logic           done;
    logic           mem_enable;
    logic           mem_rw;
    logic [AW-1:0]  mem_address;
    logic [DW-1:0]  mem_data;

    always #5 clk = ~clk;

    dma_writeback #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BLOCK_SIZE (BS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start),
        .base_addr_i   (base_addr),
        .block_in_i    (block_in),
        .ready_o       (ready),
        .done_o        (done),
        .mem_enable_o  (mem_enable),
        .mem_rw_o      (mem_rw),
        .mem_address_o (mem_address),
        .mem_data_o    (mem_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] words    [BS];
    logic [AW-1:0] obs_addr [BS];
    logic [DW-1:0] obs_data [BS];

    typedef struct {
        logic [AW-1:0] base;
        logic [DW-1:0] seed;        // word j = seed + j
        logic [AW-1:0] exp_first_addr;
        logic [AW-1:0] exp_last_addr;
        logic [DW-1:0] exp_last_data;
    } vec_t;

    vec_t vecs [4];

    // Reference: value the memory should receive for a given input word
    function automatic logic [DW-1:0] model_word(input logic [DW-1:0] w);
`ifdef DMA_WB_RELU_EN
        if ($signed(w) < 0) return '0;
`endif
        return w;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic load_block();
        for (int j = 0; j < BS; j++) block_in[j*DW +: DW] = words[j];
    endtask

    // Called at a negedge with the engine idle; returns at a negedge with ready=1
    task automatic run_block(input logic [AW-1:0] base, input bit disturb);
        logic [DW-1:0] exp_d [BS];
        logic [AW-1:0] exp_a;
        for (int j = 0; j < BS; j++) exp_d[j] = model_word(words[j]);
        load_block();
        base_addr = base;
        start     = 1'b1;
        for (int k = 0; k < BS; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (disturb) begin
                start     = 1'($urandom_range(0, 1));
                base_addr = AW'($urandom);
                for (int j = 0; j < BS; j++) block_in[j*DW +: DW] = DW'($urandom);
            end
            exp_a = base + AW'(k);
            obs_addr[k] = mem_address;
            obs_data[k] = mem_data;
            check($sformatf("write%0d", k),
                  64'({ready, done, mem_enable, mem_rw, mem_address, mem_data}),
                  64'({1'b0, 1'b0, 1'b1, 1'b0, exp_a, exp_d[k]}));
        end
        @(negedge clk);
        start = 1'b0;
        check("done_pulse", 64'({ready, done, mem_enable, mem_rw}), 64'(4'b0100));
        @(negedge clk);
        check("ready_return", 64'({ready, done, mem_enable, mem_rw}), 64'(4'b1000));
    endtask

    initial begin
        vecs[0] = '{16'h0100, 16'h0001, 16'h0100, 16'h0118, 16'h0019};
        vecs[1] = '{16'hFFF0, 16'h0100, 16'hFFF0, 16'h0008, 16'h0118};
        vecs[2] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0017, 16'h0018};
`ifdef DMA_WB_RELU_EN
        vecs[3] = '{16'h1234, 16'h7FF0, 16'h1234, 16'h124C, 16'h0000};
`else
        vecs[3] = '{16'h1234, 16'h7FF0, 16'h1234, 16'h124C, 16'h8008};
`endif

        // Reset, then idle with all outputs quiet
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("idle%0d", i),
                  64'({ready, done, mem_enable, mem_rw, mem_address, mem_data}),
                  64'({1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000}));
        end

        // Table vectors, issued back to back (27-cycle period)
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < BS; j++) words[j] = vecs[i].seed + DW'(j);
            run_block(vecs[i].base, 1'b0);
            check($sformatf("vec%0d_first_addr", i), 64'(obs_addr[0]), 64'(vecs[i].exp_first_addr));
            check($sformatf("vec%0d_last_addr", i), 64'(obs_addr[BS-1]), 64'(vecs[i].exp_last_addr));
            check($sformatf("vec%0d_last_data", i), 64'(obs_data[BS-1]), 64'(vecs[i].exp_last_data));
        end

        // ReLU boundary: negative word 3, positive word 4
        for (int j = 0; j < BS; j++) words[j] = DW'(j + 1);
        words[3] = 16'hF000;
        words[4] = 16'h2000;
        run_block(16'h0040, 1'b0);
`ifdef DMA_WB_RELU_EN
        check("relu_word3", 64'(obs_data[3]), 64'(16'h0000));
`else
        check("relu_word3", 64'(obs_data[3]), 64'(16'hF000));
`endif
        check("relu_word4", 64'(obs_data[4]), 64'(16'h2000));

        // start and block_in churn during WRITE must not disturb the block
        for (int j = 0; j < BS; j++) words[j] = DW'($urandom);
        run_block(16'h0500, 1'b1);

        // Reset in the middle of a block
        for (int j = 0; j < BS; j++) words[j] = DW'(j + 1);
        load_block();
        base_addr = 16'h0200;
        start     = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("midblock_addr10", 64'({mem_enable, mem_address, mem_data}),
              64'({1'b1, 16'h020A, 16'h000B}));
        rst_n = 1'b0;
        #1;
        check("reset_async", 64'({ready, done, mem_enable, mem_rw, mem_address, mem_data}),
              64'({1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000}));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("reset_hold%0d", i), 64'(mem_enable), 64'(1'b0));
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("post_reset%0d", i),
                  64'({ready, done, mem_enable, mem_address, mem_data}),
                  64'({1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000}));
        end
        for (int j = 0; j < BS; j++) words[j] = DW'($urandom);
        run_block(16'h0300, 1'b0);

        // Randomized blocks
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < BS; j++) words[j] = DW'($urandom);
            run_block(AW'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_dma_writeback
`default_nettype wire
